regfile_scoreboard: RTL and testbench

Parametrised integer register file with synchronous write-back, two combinational read ports and a per-register busy scoreboard for the pipelined core. Issue reserves a destination register and write-back writes and releases it, so decode can detect RAW hazards on both source operands. Register 0 is hardwired to zero. The block replaces the unclocked register file between decode/issue and write-back.

---
 rtl/regfile_scoreboard.sv | 133 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard.
// It has two combinational read ports and one synchronous write-back port.
// Issue reserves a destination register and write-back releases it.
// Decode uses Busy1/Busy2 to detect RAW hazards. Register 0 reads as zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward an in-flight write-back to the read
// ports in the same cycle.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ReadReg1,
  input  logic [AW-1:0]   ReadReg2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            Busy1,
  output logic            Busy2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   WriteReg,
  input  logic [XLEN-1:0] WriteData,
  input  logic            Reserve,
  input  logic [AW-1:0]   ReserveReg,
  output logic            ReserveOk,
  input  logic            Flush,
  output logic [AW:0]     PendingCount
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  logic wr_en;
  logic wr_release;
  logic rsv_ok;
  logic rsv_accept;

  // Qualify write-back and reservation requests against the stored busy state.
  always_comb begin
    wr_en      = RegWrite && (WriteReg != '0);
    wr_release = wr_en && busy_q[WriteReg];
    rsv_ok     = (ReserveReg == '0) || !busy_q[ReserveReg];
    // A write-back that frees the very register being reserved hands ownership
    // straight to the new producer, so busy ends set and the count nets to zero.
    rsv_accept = Reserve && (ReserveReg != '0) && !Flush &&
                 (rsv_ok || (wr_en && (WriteReg == ReserveReg)));
  end

  assign ReserveOk    = rsv_ok;
  assign PendingCount = count_q;

  // Next busy vector: release on write-back, claim on accepted reserve, squash on flush.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[WriteReg] = 1'b0;
    end
    if (rsv_accept) begin
      busy_d[ReserveReg] = 1'b1;
    end
    if (Flush) begin
      busy_d = '0;
    end
  end

  // Next pending count; a release and a claim in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else if (rsv_accept && !wr_release) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!rsv_accept && wr_release) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Data array: write-back commits even during a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  // Scoreboard state: busy vector and pending counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read port 1: stored state, optionally overridden by the in-flight write-back.
  always_comb begin
    ReadData1 = '0;
    Busy1     = 1'b0;
    if (ReadReg1 != '0) begin
      ReadData1 = regs_q[ReadReg1];
      Busy1     = busy_q[ReadReg1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WriteReg == ReadReg1)) begin
        ReadData1 = WriteData;
        Busy1     = 1'b0;
      end
`endif
    end
  end

  // Read port 2: same as port 1.
  always_comb begin
    ReadData2 = '0;
    Busy2     = 1'b0;
    if (ReadReg2 != '0) begin
      ReadData2 = regs_q[ReadReg2];
      Busy2     = busy_q[ReadReg2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WriteReg == ReadReg2)) begin
        ReadData2 = WriteData;
        Busy2     = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard. It uses random traffic checked every cycle
// against an array-based model, plus directed scenarios with hand-computed expectations.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   ReadReg1, ReadReg2;
  logic [XLEN-1:0] ReadData1, ReadData2;
  logic            Busy1, Busy2;
  logic            RegWrite;
  logic [AW-1:0]   WriteReg;
  logic [XLEN-1:0] WriteData;
  logic            Reserve;
  logic [AW-1:0]   ReserveReg;
  logic            ReserveOk;
  logic            Flush;
  logic [AW:0]     PendingCount;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_scoreboard #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ReadReg1    (ReadReg1),
    .ReadReg2    (ReadReg2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .Busy1       (Busy1),
    .Busy2       (Busy2),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .Reserve     (Reserve),
    .ReserveReg  (ReserveReg),
    .ReserveOk   (ReserveOk),
    .Flush       (Flush),
    .PendingCount(PendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: plain arrays of register values and busy flags.
  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      logic [NREGS-1:0] nb;
      logic wr, take;
      nb   = m_busy;
      wr   = RegWrite && (WriteReg != 0);
      take = Reserve && (ReserveReg != 0) && !Flush &&
             (!m_busy[ReserveReg] || (wr && (WriteReg == ReserveReg)));
      if (wr) begin
        m_regs[WriteReg] <= WriteData;
        nb[WriteReg] = 1'b0;
      end
      if (take) nb[ReserveReg] = 1'b1;
      if (Flush) nb = '0;
      m_busy <= nb;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WriteReg == idx)) return WriteData;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WriteReg == idx)) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  // Compare every cycle on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    chk("ReadData1", ReadData1, exp_data(ReadReg1));
    chk("ReadData2", ReadData2, exp_data(ReadReg2));
    chk("Busy1", 64'(Busy1), 64'(exp_busy(ReadReg1)));
    chk("Busy2", 64'(Busy2), 64'(exp_busy(ReadReg2)));
    chk("ReserveOk", 64'(ReserveOk), 64'((ReserveReg == 0) || !m_busy[ReserveReg]));
    chk("PendingCount", 64'(PendingCount), 64'($countones(m_busy)));
  end

  task automatic idle();
    RegWrite   = 1'b0;
    WriteReg   = '0;
    WriteData  = '0;
    Reserve    = 1'b0;
    ReserveReg = '0;
    Flush      = 1'b0;
  endtask

  // Let one rising edge happen, then return 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b0;
    ReadReg1 = 5'd5;
    ReadReg2 = '0;
    idle();
    #1;
    chk("reset ReadData1", ReadData1, 64'h0);
    chk("reset Busy1", 64'(Busy1), 64'h0);
    chk("reset ReserveOk", 64'(ReserveOk), 64'h1);
    chk("reset PendingCount", 64'(PendingCount), 64'h0);
    step();
    rst = 1'b1;

    // Reserve x7, idle a cycle, then write x7.
    ReadReg1 = 5'd7; Reserve = 1'b1; ReserveReg = 5'd7;
    step(); idle(); #1;
    chk("x7 busy after reserve", 64'(Busy1), 64'h1);
    chk("count after reserve x7", 64'(PendingCount), 64'h1);
    step();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'h1234;
    step(); idle(); #1;
    chk("x7 data after write", ReadData1, 64'h1234);
    chk("x7 busy after write", 64'(Busy1), 64'h0);
    chk("count after write x7", 64'(PendingCount), 64'h0);

    // Reserve x3, retry while busy, then write+reserve x3 together.
    Reserve = 1'b1; ReserveReg = 5'd3;
    step(); idle(); Reserve = 1'b1; ReserveReg = 5'd3; #1;
    chk("ReserveOk x3 busy", 64'(ReserveOk), 64'h0);
    step(); idle(); ReadReg1 = 5'd3; #1;
    chk("count after rejected reserve", 64'(PendingCount), 64'h1);
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 64'hBEEF; Reserve = 1'b1; ReserveReg = 5'd3;
    step(); idle(); #1;
    chk("x3 data after wr+rsv", ReadData1, 64'hBEEF);
    chk("x3 busy after wr+rsv", 64'(Busy1), 64'h1);
    chk("count after wr+rsv", 64'(PendingCount), 64'h1);

    // Reserve x1, x2, x3 (x3 already held), then flush with write x2 and reserve x4.
    for (int r = 1; r <= 3; r++) begin
      Reserve = 1'b1; ReserveReg = AW'(r);
      step(); idle();
    end
    #1;
    chk("count before flush", 64'(PendingCount), 64'h3);
    Flush = 1'b1; RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 64'hAA;
    Reserve = 1'b1; ReserveReg = 5'd4;
    step(); idle(); ReadReg1 = 5'd2; ReadReg2 = 5'd4; #1;
    chk("count after flush", 64'(PendingCount), 64'h0);
    chk("x2 data after flush", ReadData1, 64'hAA);
    chk("x2 busy after flush", 64'(Busy1), 64'h0);
    chk("x4 busy after flush", 64'(Busy2), 64'h0);
    ReadReg1 = 5'd1; ReadReg2 = 5'd3; #1;
    chk("x1 busy after flush", 64'(Busy1), 64'h0);
    chk("x3 busy after flush", 64'(Busy2), 64'h0);

    // Index 0 ignores writes and reservations.
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 64'hFF; Reserve = 1'b1; ReserveReg = 5'd0;
    step(); idle(); ReadReg1 = 5'd0; #1;
    chk("x0 data", ReadData1, 64'h0);
    chk("x0 busy", 64'(Busy1), 64'h0);
    chk("count after x0 ops", 64'(PendingCount), 64'h0);

    // Same-cycle write and read of x9.
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h11;
    step(); idle();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h55; ReadReg2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    chk("x9 bypass before edge", ReadData2, 64'h55);
`else
    chk("x9 old value before edge", ReadData2, 64'h11);
`endif
    step(); idle(); ReadReg2 = 5'd9; #1;
    chk("x9 after edge", ReadData2, 64'h55);

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      ReadReg1   = rnd_idx();
      ReadReg2   = rnd_idx();
      RegWrite   = ($urandom_range(0, 2) == 0);
      WriteReg   = rnd_idx();
      WriteData  = {$urandom, $urandom};
      Reserve    = ($urandom_range(0, 1) == 0);
      ReserveReg = ($urandom_range(0, 4) == 0) ? WriteReg : rnd_idx();
      Flush      = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();

    // Asynchronous reset mid-cycle after putting state in place.
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h77;
    step(); idle(); Reserve = 1'b1; ReserveReg = 5'd6;
    step(); idle(); ReadReg1 = 5'd5; ReserveReg = 5'd6; #1;
    chk("x5 before reset", ReadData1, 64'h77);
    rst = 1'b0; #1;
    chk("async reset ReadData1", ReadData1, 64'h0);
    chk("async reset Busy1", 64'(Busy1), 64'h0);
    chk("async reset PendingCount", 64'(PendingCount), 64'h0);
    chk("async reset ReserveOk", 64'(ReserveOk), 64'h1);
    step();
    rst = 1'b1; #1;
    chk("x5 after reset release", ReadData1, 64'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
